pipeline_hazard_ctrl: RTL and testbench

- Central hazard controller for the 5-stage RV32I pipeline: generates per-stage stall/flush, EX-stage forwarding selects, and sequences multi-cycle data-memory waits.
- Sits beside the ID/EX/MEM/WB pipeline registers; consumes decode/EX/MEM status and drives the pipeline-register enables and clears.
- Owns the memory-wait FSM with a timeout watchdog, so decode, immediate-extend and ALU stay purely combinational.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 45 ++++
 rtl/pipeline_hazard_ctrl_fwd.sv | 15 +
 rtl/pipeline_hazard_ctrl.sv | 163 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the RV32I hazard controller: forwarding
// select codes, memory-wait FSM state encodings and the stage-control bundle.
package pipeline_hazard_ctrl_pkg;

    localparam int REG_W   = 5;
    localparam int NUM_OPS = 2;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic {
        HZ_IDLE     = 1'b0,
        HZ_MEM_WAIT = 1'b1
    } hz_state_e;

    typedef struct packed {
        logic stall_f;
        logic stall_d;
        logic stall_e;
        logic stall_m;
        logic flush_d;
        logic flush_e;
        logic flush_m;
        logic flush_w;
    } hz_ctl_t;

    // Writeback source seen by the EX stage (MEM or WB pipeline register).
    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic             reg_write;
    } wb_src_t;

    // MEM beats WB because it holds the younger result; x0 never forwards.
    function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] rs,
                                           input wb_src_t          mem,
                                           input wb_src_t          wb);
        if (mem.reg_write && (mem.rd != '0) && (mem.rd == rs))
            return FWD_MEM;
        else if (wb.reg_write && (wb.rd != '0) && (wb.rd == rs))
            return FWD_WB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd.sv
// EX-stage operand forwarding selects; one instance serves both ALU operands.
module hazard_fwd_unit
    import pipeline_hazard_ctrl_pkg::*;
(
    input  wb_src_t                          mem_src,
    input  wb_src_t                          wb_src,
    input  logic [NUM_OPS-1:0][REG_W-1:0]    ex_rs,
    output logic [NUM_OPS-1:0][1:0]          fwd
);

    for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
        assign fwd[g] = fwd_sel(ex_rs[g], mem_src, wb_src);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard controller: stage stall/flush, forwarding selects and the
// data-memory wait FSM with watchdog. Define HAZARD_PERF_EN for perf counters.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic             id_jal,
    input  logic [REG_W-1:0] ex_rs1,
    input  logic [REG_W-1:0] ex_rs2,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic             ex_br_taken,
    input  logic             ex_jalr,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_reg_write,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_reg_write,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             stall_m,
    output logic             flush_d,
    output logic             flush_e,
    output logic             flush_m,
    output logic             flush_w,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mem_busy,
    output logic             mem_timeout
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]      perf_stall_cyc,
    output logic [31:0]      perf_flush_evt
`endif
);

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYC);

    hz_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_stall;
    logic             load_use;
    hz_ctl_t          ctl;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= HZ_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            HZ_IDLE:     if (mem_req && !mem_ack) state_d = HZ_MEM_WAIT;
            HZ_MEM_WAIT: if (mem_ack)             state_d = HZ_IDLE;
            default:                              state_d = HZ_IDLE;
        endcase
    end

    // Wait counter is zero outside MEM_WAIT, so entry and exit both clear it.
    always_comb begin
        cnt_d = '0;
        if (state_q == HZ_MEM_WAIT && !mem_ack)
            cnt_d = (cnt_q == TMO) ? cnt_q : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            mem_timeout <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (state_q == HZ_MEM_WAIT && cnt_d == TMO)
                mem_timeout <= 1'b1;
        end
    end

    assign load_use = ex_mem_read && (ex_rd != '0) &&
                      ((id_rs1_used && id_rs1 == ex_rd) ||
                       (id_rs2_used && id_rs2 == ex_rd));

    // Output logic; the memory stall releases in the ack cycle itself.
    always_comb begin
        mem_busy  = (state_q == HZ_MEM_WAIT);
        mem_stall = (state_q == HZ_IDLE) ? (mem_req && !mem_ack) : !mem_ack;
        ctl       = '0;
        if (mem_stall) begin
            ctl.stall_f = 1'b1;
            ctl.stall_d = 1'b1;
            ctl.stall_e = 1'b1;
            ctl.stall_m = 1'b1;
            ctl.flush_w = 1'b1;
        end else if (ex_br_taken || ex_jalr) begin
            // A redirect held in EX by a memory stall lands here once it frees.
            ctl.flush_d = 1'b1;
            ctl.flush_e = 1'b1;
        end else if (load_use) begin
            ctl.stall_f = 1'b1;
            ctl.stall_d = 1'b1;
            ctl.flush_e = 1'b1;
        end else if (id_jal) begin
            ctl.flush_d = 1'b1;
        end
    end

    assign stall_f = ctl.stall_f;
    assign stall_d = ctl.stall_d;
    assign stall_e = ctl.stall_e;
    assign stall_m = ctl.stall_m;
    assign flush_d = ctl.flush_d;
    assign flush_e = ctl.flush_e;
    assign flush_m = ctl.flush_m;
    assign flush_w = ctl.flush_w;

    logic [NUM_OPS-1:0][REG_W-1:0] ex_rs;
    logic [NUM_OPS-1:0][1:0]       fwd;
    wb_src_t                       mem_src, wb_src;

    assign ex_rs   = {ex_rs2, ex_rs1};
    assign mem_src = '{rd: mem_rd, reg_write: mem_reg_write};
    assign wb_src  = '{rd: wb_rd,  reg_write: wb_reg_write};

    hazard_fwd_unit u_fwd (
        .mem_src (mem_src),
        .wb_src  (wb_src),
        .ex_rs   (ex_rs),
        .fwd     (fwd)
    );

    assign fwd_a = fwd[0];
    assign fwd_b = fwd[1];

    // ex_reg_write is carried for interface symmetry; forwarding keys off MEM/WB.
    logic unused_ok;
    assign unused_ok = ex_reg_write;

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_stall_cyc <= '0;
            perf_flush_evt <= '0;
        end else begin
            if (ctl.stall_f || ctl.stall_d || ctl.stall_e || ctl.stall_m)
                perf_stall_cyc <= perf_stall_cyc + 32'd1;
            if (ctl.flush_e)
                perf_flush_evt <= perf_flush_evt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: vector table plus multi-cycle
// sequences, expected results queued at drive time and compared after settle.
module tb_pipeline_hazard_ctrl;

    typedef struct packed {
        logic       rst_n;
        logic [4:0] id_rs1, id_rs2;
        logic       id_rs1_used, id_rs2_used, id_jal;
        logic [4:0] ex_rs1, ex_rs2, ex_rd;
        logic       ex_reg_write, ex_mem_read, ex_br_taken, ex_jalr;
        logic [4:0] mem_rd;
        logic       mem_reg_write;
        logic [4:0] wb_rd;
        logic       wb_reg_write;
        logic       mem_req, mem_ack;
    } in_t;

    typedef struct packed {
        logic [3:0] stall;   // f,d,e,m
        logic [3:0] flush;   // d,e,m,w
        logic [1:0] fa, fb;
        logic       busy, tmo;
    } exp_t;

    typedef struct packed {
        in_t  i;
        exp_t e;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic       id_rs1_used, id_rs2_used, id_jal;
    logic       ex_reg_write, ex_mem_read, ex_br_taken, ex_jalr;
    logic       mem_reg_write, wb_reg_write, mem_req, mem_ack;
    logic       stall_f, stall_d, stall_e, stall_m;
    logic       flush_d, flush_e, flush_m, flush_w;
    logic [1:0] fwd_a, fwd_b;
    logic       mem_busy, mem_timeout;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_cyc, perf_flush_evt;
`endif

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.TIMEOUT_CYC(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_jal(id_jal),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_br_taken(ex_br_taken), .ex_jalr(ex_jalr),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .mem_req(mem_req), .mem_ack(mem_ack),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
        .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m), .flush_w(flush_w),
        .fwd_a(fwd_a), .fwd_b(fwd_b),
        .mem_busy(mem_busy), .mem_timeout(mem_timeout)
`ifdef HAZARD_PERF_EN
        , .perf_stall_cyc(perf_stall_cyc), .perf_flush_evt(perf_flush_evt)
`endif
    );

    int    errors = 0;
    int    checks = 0;
    exp_t  exp_q[$];
    string name_q[$];
    vec_t  tbl[$];

    function automatic exp_t mk(input logic [3:0] st, input logic [3:0] fl,
                                input logic [1:0] fa, input logic [1:0] fb,
                                input logic busy, input logic tmo);
        exp_t e;
        e.stall = st; e.flush = fl; e.fa = fa; e.fb = fb; e.busy = busy; e.tmo = tmo;
        return e;
    endfunction

    function automatic in_t idle_in();
        in_t v;
        v = '0;
        v.rst_n = 1'b1;
        return v;
    endfunction

    task automatic apply(input in_t v);
        rst_n = v.rst_n;
        id_rs1 = v.id_rs1; id_rs2 = v.id_rs2;
        id_rs1_used = v.id_rs1_used; id_rs2_used = v.id_rs2_used; id_jal = v.id_jal;
        ex_rs1 = v.ex_rs1; ex_rs2 = v.ex_rs2; ex_rd = v.ex_rd;
        ex_reg_write = v.ex_reg_write; ex_mem_read = v.ex_mem_read;
        ex_br_taken = v.ex_br_taken; ex_jalr = v.ex_jalr;
        mem_rd = v.mem_rd; mem_reg_write = v.mem_reg_write;
        wb_rd = v.wb_rd; wb_reg_write = v.wb_reg_write;
        mem_req = v.mem_req; mem_ack = v.mem_ack;
    endtask

    task automatic check_one();
        exp_t  e, a;
        string n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        a.stall = {stall_f, stall_d, stall_e, stall_m};
        a.flush = {flush_d, flush_e, flush_m, flush_w};
        a.fa = fwd_a; a.fb = fwd_b; a.busy = mem_busy; a.tmo = mem_timeout;
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got st=%b fl=%b fa=%b fb=%b busy=%b tmo=%b, want st=%b fl=%b fa=%b fb=%b busy=%b tmo=%b",
                     n, a.stall, a.flush, a.fa, a.fb, a.busy, a.tmo,
                     e.stall, e.flush, e.fa, e.fb, e.busy, e.tmo);
        end
    endtask

    // Drive one cycle at the falling edge, queue the expectation, compare after settle.
    task automatic step(input in_t v, input exp_t e, input string n);
        @(negedge clk);
        apply(v);
        exp_q.push_back(e);
        name_q.push_back(n);
        #2;
        check_one();
    endtask

    localparam logic [3:0] S0 = 4'b0000, SALL = 4'b1111, SFD = 4'b1100;
    localparam logic [3:0] F0 = 4'b0000, FW = 4'b0001, FDE = 4'b1100, FE = 4'b0100, FD = 4'b1000;

    initial begin
        in_t  v;
        exp_t mstall;

        apply(idle_in());
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        v = idle_in(); v.rst_n = 1'b0;
        step(v, mk(S0, F0, 2'b00, 2'b00, 1'b0, 1'b0), "reset");

        // ---------------- vector table ----------------
        v = idle_in();
        tbl.push_back('{v, mk(S0, F0, 2'b00, 2'b00, 1'b0, 1'b0)});
        v = idle_in(); v.ex_mem_read = 1; v.ex_rd = 5; v.id_rs1 = 5; v.id_rs1_used = 1;
        tbl.push_back('{v, mk(SFD, FE, 2'b00, 2'b00, 1'b0, 1'b0)});
        v.id_rs1_used = 0;
        tbl.push_back('{v, mk(S0, F0, 2'b00, 2'b00, 1'b0, 1'b0)});
        v = idle_in(); v.ex_mem_read = 1; v.ex_rd = 0; v.id_rs1 = 0; v.id_rs1_used = 1;
        tbl.push_back('{v, mk(S0, F0, 2'b00, 2'b00, 1'b0, 1'b0)});
        v = idle_in(); v.ex_mem_read = 1; v.ex_rd = 12; v.id_rs2 = 12; v.id_rs2_used = 1; v.id_rs1 = 12;
        tbl.push_back('{v, mk(SFD, FE, 2'b00, 2'b00, 1'b0, 1'b0)});
        v = idle_in(); v.ex_br_taken = 1;
        tbl.push_back('{v, mk(S0, FDE, 2'b00, 2'b00, 1'b0, 1'b0)});
        v = idle_in(); v.ex_jalr = 1; v.ex_mem_read = 1; v.ex_rd = 3; v.id_rs1 = 3; v.id_rs1_used = 1;
        tbl.push_back('{v, mk(S0, FDE, 2'b00, 2'b00, 1'b0, 1'b0)});
        v = idle_in(); v.id_jal = 1;
        tbl.push_back('{v, mk(S0, FD, 2'b00, 2'b00, 1'b0, 1'b0)});
        v.ex_mem_read = 1; v.ex_rd = 9; v.id_rs2 = 9; v.id_rs2_used = 1;
        tbl.push_back('{v, mk(SFD, FE, 2'b00, 2'b00, 1'b0, 1'b0)});
        v = idle_in(); v.mem_rd = 7; v.wb_rd = 7; v.ex_rs1 = 7; v.mem_reg_write = 1; v.wb_reg_write = 1;
        tbl.push_back('{v, mk(S0, F0, 2'b10, 2'b00, 1'b0, 1'b0)});
        v.mem_rd = 0;
        tbl.push_back('{v, mk(S0, F0, 2'b01, 2'b00, 1'b0, 1'b0)});
        v = idle_in(); v.ex_rs2 = 0; v.mem_rd = 0; v.wb_rd = 0; v.mem_reg_write = 1; v.wb_reg_write = 1;
        tbl.push_back('{v, mk(S0, F0, 2'b00, 2'b00, 1'b0, 1'b0)});
        v = idle_in(); v.ex_rs1 = 4; v.ex_rs2 = 9; v.mem_rd = 9; v.mem_reg_write = 1; v.wb_rd = 4; v.wb_reg_write = 1;
        tbl.push_back('{v, mk(S0, F0, 2'b01, 2'b10, 1'b0, 1'b0)});
        v = idle_in(); v.ex_rs1 = 4; v.mem_rd = 4; v.mem_reg_write = 0; v.wb_rd = 4; v.wb_reg_write = 0;
        tbl.push_back('{v, mk(S0, F0, 2'b00, 2'b00, 1'b0, 1'b0)});
        v = idle_in(); v.mem_req = 1; v.mem_ack = 1; v.ex_br_taken = 1;
        tbl.push_back('{v, mk(S0, FDE, 2'b00, 2'b00, 1'b0, 1'b0)});

        foreach (tbl[k]) step(tbl[k].i, tbl[k].e, $sformatf("vec%0d", k));

        // ---------------- load-use lasts one cycle ----------------
        v = idle_in(); v.ex_mem_read = 1; v.ex_rd = 5; v.id_rs1 = 5; v.id_rs1_used = 1; v.id_rs2 = 1; v.id_rs2_used = 1;
        step(v, mk(SFD, FE, 2'b00, 2'b00, 1'b0, 1'b0), "lu_c1");
        v.ex_mem_read = 0; v.ex_rd = 0;
        step(v, mk(S0, F0, 2'b00, 2'b00, 1'b0, 1'b0), "lu_c2");

        // ---------------- 3-cycle memory wait ----------------
        v = idle_in(); v.mem_req = 1;
        step(v, mk(SALL, FW, 2'b00, 2'b00, 1'b0, 1'b0), "mw_c1");
        step(v, mk(SALL, FW, 2'b00, 2'b00, 1'b1, 1'b0), "mw_c2");
        step(v, mk(SALL, FW, 2'b00, 2'b00, 1'b1, 1'b0), "mw_c3");
        v.mem_ack = 1;
        step(v, mk(S0, F0, 2'b00, 2'b00, 1'b1, 1'b0), "mw_ack");
        step(idle_in(), mk(S0, F0, 2'b00, 2'b00, 1'b0, 1'b0), "mw_idle");

        // ---------------- branch deferred behind a memory stall ----------------
        v = idle_in(); v.mem_req = 1; v.ex_br_taken = 1;
        step(v, mk(SALL, FW, 2'b00, 2'b00, 1'b0, 1'b0), "br_c1");
        step(v, mk(SALL, FW, 2'b00, 2'b00, 1'b1, 1'b0), "br_c2");
        v.mem_ack = 1;
        step(v, mk(S0, FDE, 2'b00, 2'b00, 1'b1, 1'b0), "br_fire");
        step(idle_in(), mk(S0, F0, 2'b00, 2'b00, 1'b0, 1'b0), "br_idle");

        // ---------------- watchdog (TIMEOUT_CYC=4) ----------------
        v = idle_in(); v.mem_req = 1;
        step(v, mk(SALL, FW, 2'b00, 2'b00, 1'b0, 1'b0), "to_c1");
        for (int c = 2; c <= 5; c++)
            step(v, mk(SALL, FW, 2'b00, 2'b00, 1'b1, 1'b0), $sformatf("to_c%0d", c));
        for (int c = 6; c <= 8; c++)
            step(v, mk(SALL, FW, 2'b00, 2'b00, 1'b1, 1'b1), $sformatf("to_c%0d", c));
        v.mem_ack = 1;
        step(v, mk(S0, F0, 2'b00, 2'b00, 1'b1, 1'b1), "to_ack");
        step(idle_in(), mk(S0, F0, 2'b00, 2'b00, 1'b0, 1'b1), "to_sticky");

        // ---------------- reset in the middle of a wait ----------------
        v = idle_in(); v.mem_req = 1;
        mstall = mk(SALL, FW, 2'b00, 2'b00, 1'b0, 1'b1);
        step(v, mstall, "rw_c1");
        mstall.busy = 1'b1;
        step(v, mstall, "rw_c2");
        v = idle_in(); v.rst_n = 1'b0;
        step(v, mstall, "rw_rst");
        step(idle_in(), mk(S0, F0, 2'b00, 2'b00, 1'b0, 1'b0), "rw_after");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
